// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: instruction fields, state
// encodings and datapath select encodings.
package multicycle_ctrl_pkg;

   localparam logic [5:0] OpRtype   = 6'h00;
   localparam logic [5:0] OpOri     = 6'h0D;
   localparam logic [5:0] OpLw      = 6'h23;
   localparam logic [5:0] OpSw      = 6'h2B;
   localparam logic [5:0] OpBeq     = 6'h04;
   localparam logic [5:0] OpJ       = 6'h02;

   localparam logic [5:0] FunctAddu = 6'h21;
   localparam logic [5:0] FunctSubu = 6'h23;

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StExecR   = 4'd2,
      StExecOri = 4'd3,
      StMemAddr = 4'd4,
      StMemRd   = 4'd5,
      StMemWr   = 4'd6,
      StWbR     = 4'd7,
      StWbMem   = 4'd8,
      StBranch  = 4'd9,
      StJump    = 4'd10
   } state_e;

   typedef enum logic [1:0] {
      AluAdd = 2'b00,
      AluSub = 2'b01,
      AluOr  = 2'b10
   } alu_op_e;

   typedef enum logic [1:0] {
      SrcBRegB   = 2'b00,
      SrcBConst4 = 2'b01,
      SrcBImm    = 2'b10,
      SrcBImmSh2 = 2'b11
   } alu_src_b_e;

   typedef enum logic [1:0] {
      PcAluResult = 2'b00,
      PcAluOut    = 2'b01,
      PcJump      = 2'b10
   } pc_source_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem2reg;
      logic       reg_dst;
      logic       reg_write;
      logic       ext_op;
      logic       alu_src_a;
      alu_src_b_e alu_src_b;
      alu_op_e    alu_op;
      pc_source_e pc_source;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/mc_next_state.sv
// Instruction dispatch: maps OpCode/Funct to the first execution state and
// flags encodings the controller does not implement.
module mc_next_state
   import multicycle_ctrl_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output state_e     next_state_o,
   output logic       illegal_o
);

   always_comb begin
      next_state_o = StFetch;
      illegal_o    = 1'b0;
      case (opcode_i)
         OpRtype: begin
            if ((funct_i == FunctAddu) || (funct_i == FunctSubu)) begin
               next_state_o = StExecR;
            end else begin
               illegal_o = 1'b1;
            end
         end
         OpOri:       next_state_o = StExecOri;
         OpLw, OpSw:  next_state_o = StMemAddr;
         OpBeq:       next_state_o = StBranch;
         OpJ:         next_state_o = StJump;
         default:     illegal_o    = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: state sequencing with memory wait
// handling, and state-decoded datapath strobes.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter bit          MEM_WAIT_EN = 1'b1,
   parameter int unsigned STATE_W     = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         OpCode,
   input  logic [5:0]         Funct,
   input  logic               mem_ready,
   input  logic               Zero,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               IorD,
   output logic               IRWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               Mem2Reg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ExtOp,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic [1:0]         PCSource,
   output logic               illegal_instr,
   output logic [STATE_W-1:0] state_o
);

   state_e state_q;
   state_e dispatch_state;
   logic   dispatch_illegal;
   logic   ready;
   logic   is_sub_q;
   logic   is_rtype_q;
   logic   is_load_q;
   ctrl_t  ctrl;

   // Zero is consumed by the datapath together with PCWriteCond.
   logic   unused_inputs;
   assign unused_inputs = ^{Zero, mem_ready};

   assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

   mc_next_state u_next_state (
      .opcode_i     (OpCode),
      .funct_i      (Funct),
      .next_state_o (dispatch_state),
      .illegal_o    (dispatch_illegal)
   );

   // Instruction class is captured in DECODE so later states ignore OpCode/Funct.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StFetch;
         is_sub_q   <= 1'b0;
         is_rtype_q <= 1'b0;
         is_load_q  <= 1'b0;
      end else begin
         case (state_q)
            StFetch: begin
               if (ready) state_q <= StDecode;
            end
            StDecode: begin
               state_q    <= dispatch_state;
               is_sub_q   <= (Funct == FunctSubu);
               is_rtype_q <= (OpCode == OpRtype);
               is_load_q  <= (OpCode == OpLw);
            end
            StExecR, StExecOri: begin
               state_q <= StWbR;
            end
            StMemAddr: begin
               state_q <= is_load_q ? StMemRd : StMemWr;
            end
            StMemRd: begin
               if (ready) state_q <= StWbMem;
            end
            StMemWr: begin
               if (ready) state_q <= StFetch;
            end
            StWbR, StWbMem, StBranch, StJump: begin
               state_q <= StFetch;
            end
            default: begin
               state_q <= StFetch;
            end
         endcase
      end
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         StFetch: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SrcBConst4;
            ctrl.ir_write  = ready;
            ctrl.pc_write  = ready;
         end
         StDecode: begin
            ctrl.alu_src_b = SrcBImmSh2;
            ctrl.ext_op    = 1'b1;
            ctrl.illegal   = dispatch_illegal;
         end
         StExecR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBRegB;
            ctrl.alu_op    = is_sub_q ? AluSub : AluAdd;
         end
         StExecOri: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
            ctrl.alu_op    = AluOr;
         end
         StMemAddr: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
            ctrl.ext_op    = 1'b1;
         end
         StMemRd: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         StMemWr: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         StWbR: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = is_rtype_q;
         end
         StWbMem: begin
            ctrl.reg_write = 1'b1;
            ctrl.mem2reg   = 1'b1;
         end
         StBranch: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SrcBRegB;
            ctrl.alu_op        = AluSub;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PcAluOut;
         end
         StJump: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PcJump;
         end
         default: begin
            ctrl = '0;
         end
      endcase
      // Reset silences every strobe immediately, not just from the next edge.
      if (!rst_n) ctrl = '0;
   end

   assign PCWrite       = ctrl.pc_write;
   assign PCWriteCond   = ctrl.pc_write_cond;
   assign IorD          = ctrl.i_or_d;
   assign IRWrite       = ctrl.ir_write;
   assign MemRead       = ctrl.mem_read;
   assign MemWrite      = ctrl.mem_write;
   assign Mem2Reg       = ctrl.mem2reg;
   assign RegDst        = ctrl.reg_dst;
   assign RegWrite      = ctrl.reg_write;
   assign ExtOp         = ctrl.ext_op;
   assign ALUSrcA       = ctrl.alu_src_a;
   assign ALUSrcB       = ctrl.alu_src_b;
   assign ALUOp         = ctrl.alu_op;
   assign PCSource      = ctrl.pc_source;
   assign illegal_instr = ctrl.illegal;
   assign state_o       = rst_n ? STATE_W'(state_q) : STATE_W'(StFetch);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench: expected per-cycle controls come from a
// per-instruction cycle plan built from the instruction semantics.
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] OpCode = '0;
   logic [5:0] Funct = '0;
   logic       mem_ready = 1'b0;
   logic       Zero = 1'b0;

   logic a_pcw, a_pcwc, a_iord, a_irw, a_mrd, a_mwr, a_m2r, a_rdst, a_rwr, a_ext, a_srca, a_ill;
   logic [1:0] a_srcb, a_aluop, a_pcsrc;
   logic [3:0] a_state;
   logic b_pcw, b_pcwc, b_iord, b_irw, b_mrd, b_mwr, b_m2r, b_rdst, b_rwr, b_ext, b_srca, b_ill;
   logic [1:0] b_srcb, b_aluop, b_pcsrc;
   logic [3:0] b_state;

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_WAIT_EN(1'b1), .STATE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
      .Zero(Zero), .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .IRWrite(a_irw),
      .MemRead(a_mrd), .MemWrite(a_mwr), .Mem2Reg(a_m2r), .RegDst(a_rdst), .RegWrite(a_rwr),
      .ExtOp(a_ext), .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ALUOp(a_aluop), .PCSource(a_pcsrc),
      .illegal_instr(a_ill), .state_o(a_state)
   );

   multicycle_ctrl #(.MEM_WAIT_EN(1'b0), .STATE_W(4)) dut_nowait (
      .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Funct(Funct), .mem_ready(1'b0),
      .Zero(Zero), .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .IRWrite(b_irw),
      .MemRead(b_mrd), .MemWrite(b_mwr), .Mem2Reg(b_m2r), .RegDst(b_rdst), .RegWrite(b_rwr),
      .ExtOp(b_ext), .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .ALUOp(b_aluop), .PCSource(b_pcsrc),
      .illegal_instr(b_ill), .state_o(b_state)
   );

   typedef struct packed {
      logic pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rwr, ext, srca;
      logic [1:0] srcb, aluop, pcsrc;
      logic ill;
   } ctl_t;

   typedef struct packed {
      ctl_t       c;
      logic [3:0] st;
      logic       rdy;
      logic [5:0] op;
      logic [5:0] fn;
      logic       rst;
   } step_t;

   ctl_t obs_a, obs_b;
   assign obs_a = {a_pcw, a_pcwc, a_iord, a_irw, a_mrd, a_mwr, a_m2r, a_rdst, a_rwr, a_ext,
                   a_srca, a_srcb, a_aluop, a_pcsrc, a_ill};
   assign obs_b = {b_pcw, b_pcwc, b_iord, b_irw, b_mrd, b_mwr, b_m2r, b_rdst, b_rwr, b_ext,
                   b_srca, b_srcb, b_aluop, b_pcsrc, b_ill};

   step_t plan[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    cyc = 0;
   bit    chk_nowait = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] rnd6();
      return 6'($urandom);
   endfunction

   task automatic push(input ctl_t c, input logic [3:0] st, input logic rdy,
                       input logic [5:0] op, input logic [5:0] fn);
      step_t s;
      s.c = c; s.st = st; s.rdy = rdy; s.op = op; s.fn = fn; s.rst = 1'b1;
      plan.push_back(s);
   endtask

   task automatic push_rst();
      step_t s;
      s = '0;
      s.st = StFetch; s.op = rnd6(); s.fn = rnd6(); s.rdy = 1'($urandom);
      plan.push_back(s);
   endtask

   // Expected cycle sequence of one instruction; fw/mw = wait cycles in fetch/memory.
   task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mw);
      ctl_t c;
      bit   legal;
      bit   is_lw;
      legal = ((op == 6'h00) && (fn == 6'h21 || fn == 6'h23)) || op == 6'h0D ||
              op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02;
      c = '0; c.mrd = 1'b1; c.srcb = 2'b01;
      for (int i = 0; i < fw; i++) push(c, StFetch, 1'b0, rnd6(), rnd6());
      c.irw = 1'b1; c.pcw = 1'b1;
      push(c, StFetch, 1'b1, rnd6(), rnd6());
      c = '0; c.srcb = 2'b11; c.ext = 1'b1; c.ill = !legal;
      push(c, StDecode, 1'($urandom), op, fn);
      if (legal) begin
         c = '0;
         case (op)
            6'h00, 6'h0D: begin
               c.srca = 1'b1;
               if (op == 6'h00) begin
                  c.aluop = (fn == 6'h23) ? 2'b01 : 2'b00;
                  push(c, StExecR, 1'($urandom), rnd6(), rnd6());
               end else begin
                  c.srcb = 2'b10; c.aluop = 2'b10;
                  push(c, StExecOri, 1'($urandom), rnd6(), rnd6());
               end
               c = '0; c.rwr = 1'b1; c.rdst = (op == 6'h00);
               push(c, StWbR, 1'($urandom), rnd6(), rnd6());
            end
            6'h23, 6'h2B: begin
               is_lw = (op == 6'h23);
               c.srca = 1'b1; c.srcb = 2'b10; c.ext = 1'b1;
               push(c, StMemAddr, 1'($urandom), rnd6(), rnd6());
               c = '0; c.iord = 1'b1; c.mrd = is_lw; c.mwr = !is_lw;
               for (int i = 0; i <= mw; i++)
                  push(c, is_lw ? StMemRd : StMemWr, (i == mw), rnd6(), rnd6());
               if (is_lw) begin
                  c = '0; c.rwr = 1'b1; c.m2r = 1'b1;
                  push(c, StWbMem, 1'($urandom), rnd6(), rnd6());
               end
            end
            6'h04: begin
               c.srca = 1'b1; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 2'b01;
               push(c, StBranch, 1'($urandom), rnd6(), rnd6());
            end
            default: begin
               c.pcw = 1'b1; c.pcsrc = 2'b10;
               push(c, StJump, 1'($urandom), rnd6(), rnd6());
            end
         endcase
      end
   endtask

   task automatic step(input step_t s);
      rst_n = s.rst; mem_ready = s.rdy; OpCode = s.op; Funct = s.fn; Zero = 1'($urandom);
      @(negedge clk);
      check($sformatf("ctl[%0d]", cyc), 32'(obs_a), 32'(s.c));
      check($sformatf("state[%0d]", cyc), 32'(a_state), 32'(s.st));
      if (chk_nowait) begin
         check($sformatf("nowait_ctl[%0d]", cyc), 32'(obs_b), 32'(s.c));
         check($sformatf("nowait_state[%0d]", cyc), 32'(b_state), 32'(s.st));
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n && plan.size() > 0; i++) step(plan.pop_front());
   endtask

   initial begin
      logic [5:0] op, fn;
      for (int i = 0; i < 3; i++) push_rst();
      drain(plan.size());

      // Unit without wait handling sees mem_ready stuck at 0 throughout.
      chk_nowait = 1'b1;
      plan_instr(6'h2B, rnd6(), 0, 0);
      plan_instr(6'h23, rnd6(), 0, 0);
      plan_instr(6'h00, 6'h21, 0, 0);
      plan_instr(6'h04, rnd6(), 0, 0);
      drain(plan.size());
      chk_nowait = 1'b0;

      plan_instr(6'h00, 6'h21, 0, 0);
      plan_instr(6'h23, rnd6(), 2, 2);
      plan_instr(6'h04, rnd6(), 0, 0);
      plan_instr(6'h04, rnd6(), 0, 0);
      plan_instr(6'h3F, rnd6(), 0, 0);
      plan_instr(6'h00, 6'h20, 0, 0);
      plan_instr(6'h00, 6'h23, 1, 0);
      plan_instr(6'h0D, rnd6(), 0, 0);
      plan_instr(6'h02, rnd6(), 0, 0);
      plan_instr(6'h2B, rnd6(), 0, 1);
      drain(plan.size());

      for (int i = 0; i < 80; i++) begin
         fn = rnd6();
         case ($urandom_range(0, 7))
            0: begin op = 6'h00; fn = ($urandom_range(0, 1) != 0) ? 6'h21 : 6'h23; end
            1: op = 6'h0D;
            2: op = 6'h23;
            3: op = 6'h2B;
            4: op = 6'h04;
            5: op = 6'h02;
            6: op = 6'h00;
            default: op = rnd6();
         endcase
         plan_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2));
      end
      drain(plan.size());

      // Reset while a store waits on memory: abandon it and refetch.
      plan_instr(6'h2B, rnd6(), 0, 3);
      drain(4);
      plan.delete();
      push_rst();
      plan_instr(6'h0D, rnd6(), 1, 0);
      plan_instr(6'h23, rnd6(), 0, 1);
      drain(plan.size());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MEM_WAIT_EN, 1, when 0 mem_ready is ignored and treated as 1.
REQ-002 Parameter: STATE_W, 4, width of state_o.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 OpCode  input  6  instruction[31:26], taken from instruction register.
REQ-006 Funct  input  6  instruction[5:0].
REQ-007 mem_ready  input  1  memory completes the current read/write this cycle.
REQ-008 Zero  input  1  ALU zero flag, BEQ condition.
REQ-009 PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, Mem2Reg, RegDst, RegWrite, ExtOp  output  1 each  datapath strobes/selects.
REQ-010 ALUSrcA  output  1  0=PC, 1=reg A.
REQ-011 ALUSrcB  output  2  00=reg B, 01=const 4, 10=extended imm, 11=extended imm<<2.
REQ-012 ALUOp  output  2  00=ADD, 01=SUB, 10=OR.
REQ-013 PCSource  output  2  00=ALU result, 01=ALUOut register, 10=jump target.
REQ-014 illegal_instr  output  1  one-cycle pulse on undecodable instruction.
REQ-015 state_o  output  STATE_W  current state encoding, debug.

Function
REQ-016 States SHALL be: FETCH, DECODE, EXEC_R, EXEC_ORI, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_MEM, BRANCH, JUMP.
REQ-017 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00; IRWrite=PCWrite=1 only in the cycle mem_ready=1; stay in FETCH until mem_ready=1, then DECODE.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD, ExtOp=1 (branch target precompute); next state by OpCode/Funct.
REQ-019 Decode: OpCode 0x00 with Funct 0x21 (ADDU) or 0x23 (SUBU) -> EXEC_R; 0x0D (ORI) -> EXEC_ORI; 0x23 (LW) or 0x2B (SW) -> MEM_ADDR; 0x04 (BEQ) -> BRANCH; 0x02 (J) -> JUMP.
REQ-020 Any other OpCode, or OpCode 0x00 with other Funct: illegal_instr=1 in DECODE, next state FETCH, no register/memory/PC write.
REQ-021 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=ADD (ADDU) or SUB (SUBU); -> WB_R.
REQ-022 EXEC_ORI: ALUSrcA=1, ALUSrcB=10, ExtOp=0, ALUOp=OR; -> WB_R.
REQ-023 WB_R: RegWrite=1, Mem2Reg=0, RegDst=1 for R-type, 0 for ORI; -> FETCH.
REQ-024 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=ADD; -> MEM_RD (LW) or MEM_WR (SW).
REQ-025 MEM_RD: MemRead=1, IorD=1; hold until mem_ready=1, then WB_MEM.
REQ-026 MEM_WR: MemWrite=1, IorD=1; hold until mem_ready=1, then FETCH.
REQ-027 WB_MEM: RegWrite=1, Mem2Reg=1, RegDst=0; -> FETCH.
REQ-028 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01; -> FETCH.
REQ-029 JUMP: PCWrite=1, PCSource=10; -> FETCH.
REQ-030 Any strobe/select not listed for a state SHALL be 0.
REQ-031 OpCode/Funct SHALL be sampled only in DECODE; changes elsewhere have no effect.
REQ-032 Latency with mem_ready always 1: R/ORI 4 cycles, LW 5, SW 4, BEQ 3, J 3, illegal 2.
REQ-033 Each wait cycle on mem_ready=0 adds exactly one cycle; MemRead/MemWrite held stable during wait, IRWrite/PCWrite stay 0.

Reset
REQ-034 rst_n=0 at a rising edge SHALL force state to FETCH regardless of current state, abandoning any pending memory access.
REQ-035 While rst_n=0 all outputs SHALL be 0 and state_o SHALL read the FETCH encoding.
REQ-036 First cycle with rst_n=1 SHALL drive FETCH outputs.

Structure
REQ-037 Opcode/funct constants, state encodings, ALUOp/ALUSrcB/PCSource encodings SHALL live in the shared instruction/signal definition headers.
REQ-038 One sub-module, mc_next_state (combinational OpCode/Funct -> dispatch state, illegal flag), is permitted; outputs are state-decoded in the top.

Verification
REQ-039 Reset then ADDU (0x00/0x21), mem_ready=1 -> states FETCH,DECODE,EXEC_R,WB_R; RegWrite=1, RegDst=1 in cycle 4 only.
REQ-040 LW (0x23) with mem_ready=0 for 2 cycles in FETCH and MEM_RD -> 9 cycles total, IRWrite single pulse, Mem2Reg=RegWrite=1 in final cycle.
REQ-041 BEQ (0x04) with Zero=1 then Zero=0 -> both take 3 cycles, PCWriteCond=1, PCSource=01 in BRANCH.
REQ-042 OpCode 0x3F, then 0x00/0x20 -> illegal_instr pulses once each, no RegWrite/MemWrite/PCWrite after FETCH.
REQ-043 rst_n=0 asserted during MEM_WR with mem_ready=0 -> next cycle MemWrite=0, state FETCH; after release fetch restarts.
REQ-044 MEM_WAIT_EN=0, mem_ready tied 0, SW (0x2B) -> completes in 4 cycles.
